// File: rtl/uart_tx_feeder.sv
// Key-press byte capture, FIFO queue and start/busy handoff to the UART transmitter.
// Optional auto-repeat while held: define UART_TX_FEEDER_REPEAT_EN.
module uart_tx_feeder #(
  parameter int DATA_W          = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 1024,
  parameter int REPEAT_CYCLES   = 12500000,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic [AW:0]       fifo_count,
  output logic              fifo_full,
  output logic              overflow,
  output logic              ack_err
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  if ((ACK_TIMEOUT < 2) || (DEBOUNCE_CYCLES < 1) || (REPEAT_CYCLES < 1))
    $error("bad timing parameter");

  // Async assert, sync release
  logic [1:0] rst_q;
  logic       rst_sync_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_sync_n = rst_q[1];

  logic          k1, k2, deb, deb_q;
  logic [DW-1:0] dcnt;
  logic          press, push;

  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      k1    <= 1'b1;
      k2    <= 1'b1;
      deb   <= 1'b1;
      deb_q <= 1'b1;
      dcnt  <= '0;
    end else begin
      k1    <= key_n;
      k2    <= k1;
      deb_q <= deb;
      if (k2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb  <= k2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb;

`ifdef UART_TX_FEEDER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rcnt;
  logic          rep_hit;

  assign rep_hit = ~deb & ~press & (rcnt == RW'(REPEAT_CYCLES - 1));

  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n)                  rcnt <= '0;
    else if (deb || press || rep_hit) rcnt <= '0;
    else                              rcnt <= rcnt + 1'b1;
  end

  assign push = press | rep_hit;
`else
  assign push = press;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [1:0]        state;
  logic [TW-1:0]     tcnt;
  logic              pop, do_push;

  assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && (fifo_count != '0) && !tx_busy;
  // A pop in the same cycle frees the slot even when full
  assign do_push   = push && (!fifo_full || pop);
  assign tx_start  = (state == START);

  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr] <= sw_data;
  end

  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!do_push && pop) fifo_count <= fifo_count - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // tcnt counts cycles since tx_start, START cycle included
  always_ff @(posedge Clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state   <= IDLE;
      tx_data <= '0;
      tcnt    <= '0;
      ack_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rptr];
            tcnt    <= '0;
            state   <= START;
          end
        end
        START: begin
          tcnt  <= tcnt + 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
